// File: rtl/rice_core_pkg.sv
// Shared types for the rice core bus fabric: bus source tags and a helper
// for round-robin alternation between the two core masters.
package rice_core_pkg;

  typedef enum logic {
    RICE_BUS_SOURCE_INST = 1'b0,
    RICE_BUS_SOURCE_DATA = 1'b1
  } rice_bus_source_e;

  localparam int RICE_BUS_SOURCE_COUNT = 2;

  function automatic rice_bus_source_e rice_bus_other_source(input rice_bus_source_e src);
    rice_bus_source_e other;
    case (src)
      RICE_BUS_SOURCE_INST: other = RICE_BUS_SOURCE_DATA;
      RICE_BUS_SOURCE_DATA: other = RICE_BUS_SOURCE_INST;
      default:              other = RICE_BUS_SOURCE_INST;
    endcase
    return other;
  endfunction

endpackage

// File: rtl/rice_bus_if.sv
// Simple valid/ready request bus with an always-accepted response channel.
// The master issues requests; the slave answers with responses.
interface rice_bus_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int XLEN          = 32
);

  logic                     request_valid;
  logic                     request_ready;
  logic                     request_write;
  logic [ADDRESS_WIDTH-1:0] request_address;
  logic [XLEN-1:0]          request_data;
  logic [XLEN/8-1:0]        request_strobe;
  logic                     response_valid;
  logic [XLEN-1:0]          response_data;
  logic                     response_error;

  modport master (
    output request_valid,
    input  request_ready,
    output request_write,
    output request_address,
    output request_data,
    output request_strobe,
    input  response_valid,
    input  response_data,
    input  response_error
  );

  modport slave (
    input  request_valid,
    output request_ready,
    input  request_write,
    input  request_address,
    input  request_data,
    input  request_strobe,
    output response_valid,
    output response_data,
    output response_error
  );

endinterface

// File: rtl/rice_bus_arbiter_fifo.sv
// In-order tag FIFO recording which master issued each outstanding request.
// Push and pop may coincide at any occupancy, including full.
module rice_bus_arbiter_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  logic push_data_i,
  input  logic pop_i,
  output logic full_o,
  output logic empty_o,
  output logic head_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0] mem_q;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
    logic [PTR_W-1:0] nxt;
    if (ptr == PTR_W'(DEPTH - 1)) begin
      nxt = {PTR_W{1'b0}};
    end else begin
      nxt = ptr + PTR_W'(1);
    end
    return nxt;
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == {CNT_W{1'b0}});
  assign head_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO only lands when the head leaves in the same cycle.
  always_comb begin
    pop_ok   = pop_i && !empty_o;
    push_ok  = push_i && (!full_o || pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = ptr_next(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok) begin
      rd_ptr_d = ptr_next(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q    <= {DEPTH{1'b0}};
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data_i;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/rice_bus_arbiter.sv
// Merges the core's instruction and data masters onto one memory master port
// with round-robin arbitration, stall locking and in-order response routing.
module rice_bus_arbiter
  import rice_core_pkg::*;
#(
  parameter int XLEN            = 32,
  parameter int ADDRESS_WIDTH   = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic      i_clk,
  input  logic      i_rst,
  rice_bus_if.slave  inst_bus_if,
  rice_bus_if.slave  data_bus_if,
  rice_bus_if.master memory_bus_if,
  output logic      o_response_error
);

  rice_bus_source_e         grant_q, grant_d;
  rice_bus_source_e         last_grant_q, last_grant_d;
  logic                     lock_q, lock_d;
  logic                     error_q, error_d;

  rice_bus_source_e         grant_sel;
  rice_bus_source_e         head_src;
  logic                     sel_valid;
  logic                     sel_write;
  logic [ADDRESS_WIDTH-1:0] sel_address;
  logic [XLEN-1:0]          sel_data;
  logic [XLEN/8-1:0]        sel_strobe;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     fifo_head;
  logic                     fifo_pop;
  logic                     can_issue;
  logic                     mem_req_valid;
  logic                     transfer;
  logic                     resp_to_inst;
  logic                     resp_to_data;

  // Grant selection: a stalled grant is held, otherwise round-robin on ties.
  always_comb begin
    grant_sel = last_grant_q;
    if (lock_q) begin
      grant_sel = grant_q;
    end else if (inst_bus_if.request_valid && data_bus_if.request_valid) begin
      grant_sel = rice_bus_other_source(last_grant_q);
    end else if (inst_bus_if.request_valid) begin
      grant_sel = RICE_BUS_SOURCE_INST;
    end else if (data_bus_if.request_valid) begin
      grant_sel = RICE_BUS_SOURCE_DATA;
    end else begin
      grant_sel = rice_bus_other_source(last_grant_q);
    end
  end

  // Request payload mux from the granted master.
  always_comb begin
    sel_valid   = 1'b0;
    sel_write   = 1'b0;
    sel_address = {ADDRESS_WIDTH{1'b0}};
    sel_data    = {XLEN{1'b0}};
    sel_strobe  = {(XLEN/8){1'b0}};
    case (grant_sel)
      RICE_BUS_SOURCE_INST: begin
        sel_valid   = inst_bus_if.request_valid;
        sel_write   = inst_bus_if.request_write;
        sel_address = inst_bus_if.request_address;
        sel_data    = inst_bus_if.request_data;
        sel_strobe  = inst_bus_if.request_strobe;
      end
      RICE_BUS_SOURCE_DATA: begin
        sel_valid   = data_bus_if.request_valid;
        sel_write   = data_bus_if.request_write;
        sel_address = data_bus_if.request_address;
        sel_data    = data_bus_if.request_data;
        sel_strobe  = data_bus_if.request_strobe;
      end
      default: begin
        sel_valid   = 1'b0;
        sel_write   = 1'b0;
        sel_address = {ADDRESS_WIDTH{1'b0}};
        sel_data    = {XLEN{1'b0}};
        sel_strobe  = {(XLEN/8){1'b0}};
      end
    endcase
  end

  // A response draining the head frees a slot for a request in the same cycle.
  assign head_src      = rice_bus_source_e'(fifo_head);
  assign fifo_pop      = memory_bus_if.response_valid && !fifo_empty && !i_rst;
  assign can_issue     = !fifo_full || fifo_pop;
  assign mem_req_valid = sel_valid && can_issue && !i_rst;
  assign transfer      = mem_req_valid && memory_bus_if.request_ready;

  assign memory_bus_if.request_valid   = mem_req_valid;
  assign memory_bus_if.request_write   = sel_write;
  assign memory_bus_if.request_address = sel_address;
  assign memory_bus_if.request_data    = sel_data;
  assign memory_bus_if.request_strobe  = sel_strobe;

  assign inst_bus_if.request_ready = (grant_sel == RICE_BUS_SOURCE_INST) && can_issue
                                     && memory_bus_if.request_ready && !i_rst;
  assign data_bus_if.request_ready = (grant_sel == RICE_BUS_SOURCE_DATA) && can_issue
                                     && memory_bus_if.request_ready && !i_rst;

  assign resp_to_inst = fifo_pop && (head_src == RICE_BUS_SOURCE_INST);
  assign resp_to_data = fifo_pop && (head_src == RICE_BUS_SOURCE_DATA);

  assign inst_bus_if.response_valid = resp_to_inst;
  assign inst_bus_if.response_data  = memory_bus_if.response_data;
  assign inst_bus_if.response_error = resp_to_inst && memory_bus_if.response_error;
  assign data_bus_if.response_valid = resp_to_data;
  assign data_bus_if.response_data  = memory_bus_if.response_data;
  assign data_bus_if.response_error = resp_to_data && memory_bus_if.response_error;

  assign o_response_error = error_q;

  rice_bus_arbiter_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_source_fifo (
    .clk_i       (i_clk),
    .rst_i       (i_rst),
    .push_i      (transfer),
    .push_data_i (grant_sel),
    .pop_i       (fifo_pop),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (fifo_head)
  );

  // Next-state for lock, grant history and the sticky orphan-response flag.
  always_comb begin
    lock_d  = mem_req_valid && !memory_bus_if.request_ready;
    grant_d = grant_sel;
    error_d = error_q || (memory_bus_if.response_valid && fifo_empty);
    if (transfer) begin
      last_grant_d = grant_sel;
    end else begin
      last_grant_d = last_grant_q;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      grant_q      <= RICE_BUS_SOURCE_DATA;
      last_grant_q <= RICE_BUS_SOURCE_DATA;
      lock_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      lock_q       <= lock_d;
      error_q      <= error_d;
    end
  end

endmodule
